uart_cmd_decoder: RTL and testbench

- Sits between the UART receiver (115200 baud, 25 MHz PLL clock domain) and the Pong game core.
- Parses framed command packets from the UART byte stream.
- Produces the game-start pulse and remote paddle up/down levels, so a host PC can drive the game alongside or instead of the push buttons.
- Counts malformed or timed-out packets for debug.

---
 rtl/uart_cmd_decoder.sv | 237 +++++++++++++++++++++++
 tb/tb_uart_cmd_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_decoder.sv
// Decodes framed UART command packets (A5, CMD, ARG [, SUM]) into game-start and paddle controls.
// Optional macro UART_CMD_CHECKSUM_EN adds a fourth SUM byte that must equal 0xA5 ^ CMD ^ ARG.
module uart_cmd_decoder #(
  parameter int TIMEOUT_CLKS = 25000,
  parameter int HOLD_CLKS    = 250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Game_Start,
  output logic       o_Paddle_Up_P1,
  output logic       o_Paddle_Dn_P1,
  output logic       o_Paddle_Up_P2,
  output logic       o_Paddle_Dn_P2,
  output logic [7:0] o_Err_Count
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_UP    = 8'h55;
  localparam logic [7:0] CMD_DN    = 8'h44;

  localparam int TO_W   = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS + 1);
  localparam int HOLD_W = (HOLD_CLKS < 2) ? 1 : $clog2(HOLD_CLKS + 1);

  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CLKS);

`ifdef UART_CMD_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_CMD = 3'd1,
    GET_ARG = 3'd2,
    GET_SUM = 3'd3,
    EXEC    = 3'd4
  } t_State;
`else
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GET_CMD = 2'd1,
    GET_ARG = 2'd2,
    EXEC    = 2'd3
  } t_State;
`endif

  t_State r_State;
  t_State w_NextState;

  logic [7:0]        r_Cmd;
  logic [7:0]        r_Arg;
  logic [TO_W-1:0]   r_ToCnt;
  logic              w_Timeout;

  logic              w_SumOk;
  logic              w_ArgOk;
  logic              w_ExecStart;
  logic              w_ExecPaddle;
  logic              w_ExecErr;

  logic              r_StartReq;
  logic              r_ErrReq;
  logic              r_P1Load;
  logic              r_P2Load;
  logic              r_LoadUp;

  logic [HOLD_W-1:0] r_Hold1;
  logic [HOLD_W-1:0] r_Hold2;
  logic              r_Dir1Up;
  logic              r_Dir2Up;

`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]        r_Sum;
`endif

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State <= IDLE;
    end else begin
      r_State <= w_NextState;
    end
  end

  // Every transition except EXEC->IDLE waits for a byte; a silent gap times out back to IDLE.
  always_comb begin
    w_NextState = r_State;
    w_Timeout   = 1'b0;
    case (r_State)
      IDLE: begin
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
          w_NextState = GET_CMD;
        end
      end
      GET_CMD: begin
        if (i_RX_DV) begin
          w_NextState = GET_ARG;
        end else if (r_ToCnt == TO_LAST) begin
          w_NextState = IDLE;
          w_Timeout   = 1'b1;
        end
      end
      GET_ARG: begin
        if (i_RX_DV) begin
`ifdef UART_CMD_CHECKSUM_EN
          w_NextState = GET_SUM;
`else
          w_NextState = EXEC;
`endif
        end else if (r_ToCnt == TO_LAST) begin
          w_NextState = IDLE;
          w_Timeout   = 1'b1;
        end
      end
`ifdef UART_CMD_CHECKSUM_EN
      GET_SUM: begin
        if (i_RX_DV) begin
          w_NextState = EXEC;
        end else if (r_ToCnt == TO_LAST) begin
          w_NextState = IDLE;
          w_Timeout   = 1'b1;
        end
      end
`endif
      EXEC: begin
        w_NextState = IDLE;
      end
      default: begin
        w_NextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Cmd <= 8'h00;
      r_Arg <= 8'h00;
    end else if (i_RX_DV) begin
      if (r_State == GET_CMD) begin
        r_Cmd <= i_RX_Byte;
      end
      if (r_State == GET_ARG) begin
        r_Arg <= i_RX_Byte;
      end
    end
  end

`ifdef UART_CMD_CHECKSUM_EN
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Sum <= 8'h00;
    end else if (i_RX_DV && (r_State == GET_SUM)) begin
      r_Sum <= i_RX_Byte;
    end
  end

  assign w_SumOk = (r_Sum == (SYNC_BYTE ^ r_Cmd ^ r_Arg));
`else
  assign w_SumOk = 1'b1;
`endif

  // Gap counter only runs while a packet is partially received.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_ToCnt <= '0;
    end else if ((r_State == IDLE) || (r_State == EXEC) || i_RX_DV || w_Timeout) begin
      r_ToCnt <= '0;
    end else begin
      r_ToCnt <= r_ToCnt + 1'b1;
    end
  end

  assign w_ArgOk      = (r_Arg == 8'h01) || (r_Arg == 8'h02);
  assign w_ExecStart  = (r_State == EXEC) && w_SumOk && (r_Cmd == CMD_START);
  assign w_ExecPaddle = (r_State == EXEC) && w_SumOk && w_ArgOk &&
                        ((r_Cmd == CMD_UP) || (r_Cmd == CMD_DN));
  assign w_ExecErr    = (r_State == EXEC) && !w_ExecStart && !w_ExecPaddle;

  // EXEC decisions are registered once more so every output moves two edges after the last byte.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_StartReq <= 1'b0;
      r_ErrReq   <= 1'b0;
      r_P1Load   <= 1'b0;
      r_P2Load   <= 1'b0;
      r_LoadUp   <= 1'b0;
    end else begin
      r_StartReq <= w_ExecStart;
      r_ErrReq   <= w_ExecErr || w_Timeout;
      r_P1Load   <= w_ExecPaddle && (r_Arg == 8'h01);
      r_P2Load   <= w_ExecPaddle && (r_Arg == 8'h02);
      r_LoadUp   <= (r_Cmd == CMD_UP);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_Game_Start <= 1'b0;
      o_Err_Count  <= 8'h00;
    end else begin
      o_Game_Start <= r_StartReq;
      if (r_ErrReq && (o_Err_Count != 8'hFF)) begin
        o_Err_Count <= o_Err_Count + 8'd1;
      end
    end
  end

  // A load overrides any running hold, so a reversal swaps direction on a single edge.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Hold1  <= '0;
      r_Dir1Up <= 1'b0;
    end else if (r_P1Load) begin
      r_Hold1  <= HOLD_LOAD;
      r_Dir1Up <= r_LoadUp;
    end else if (r_Hold1 != '0) begin
      r_Hold1  <= r_Hold1 - 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Hold2  <= '0;
      r_Dir2Up <= 1'b0;
    end else if (r_P2Load) begin
      r_Hold2  <= HOLD_LOAD;
      r_Dir2Up <= r_LoadUp;
    end else if (r_Hold2 != '0) begin
      r_Hold2  <= r_Hold2 - 1'b1;
    end
  end

  assign o_Paddle_Up_P1 = (r_Hold1 != '0) &&  r_Dir1Up;
  assign o_Paddle_Dn_P1 = (r_Hold1 != '0) && !r_Dir1Up;
  assign o_Paddle_Up_P2 = (r_Hold2 != '0) &&  r_Dir2Up;
  assign o_Paddle_Dn_P2 = (r_Hold2 != '0) && !r_Dir2Up;

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Randomized bench for uart_cmd_decoder: a packet-level event model predicts every output on every cycle.
// Honours UART_CMD_CHECKSUM_EN the same way the design does.
module tb_uart_cmd_decoder;

  localparam int HOLD = 16;
  localparam int TMO  = 32;
`ifdef UART_CMD_CHECKSUM_EN
  localparam int PKT_LEN       = 4;
  localparam int ERR_AFTER_TMO = 4;
`else
  localparam int PKT_LEN       = 3;
  localparam int ERR_AFTER_TMO = 3;
`endif

  localparam int K_START = 0;
  localparam int K_UP1   = 1;
  localparam int K_DN1   = 2;
  localparam int K_UP2   = 3;
  localparam int K_DN2   = 4;
  localparam int K_ERR   = 5;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       dv     = 1'b0;
  logic [7:0] rxByte = 8'h00;
  logic       o_Game_Start;
  logic       o_Paddle_Up_P1;
  logic       o_Paddle_Dn_P1;
  logic       o_Paddle_Up_P2;
  logic       o_Paddle_Dn_P2;
  logic [7:0] o_Err_Count;

  uart_cmd_decoder #(.TIMEOUT_CLKS(TMO), .HOLD_CLKS(HOLD)) dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_RX_DV        (dv),
    .i_RX_Byte      (rxByte),
    .o_Game_Start   (o_Game_Start),
    .o_Paddle_Up_P1 (o_Paddle_Up_P1),
    .o_Paddle_Dn_P1 (o_Paddle_Dn_P1),
    .o_Paddle_Up_P2 (o_Paddle_Up_P2),
    .o_Paddle_Dn_P2 (o_Paddle_Dn_P2),
    .o_Err_Count    (o_Err_Count)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    int          kind;
  } evt_t;
  evt_t evq[$];

  int nChecks = 0;
  int nPass   = 0;

  int unsigned mEnd1 = 0, mEnd2 = 0, mStartAt = 0;
  bit          mUp1 = 1'b0, mUp2 = 1'b0, mStartValid = 1'b0;
  int          mErr = 0;

  int          cntStart = 0, cntUp1 = 0, cntDn1 = 0, cntUp2 = 0, cntDn2 = 0;
  int unsigned lastStartCyc = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual == expected) nPass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Model: an accepted packet acts two edges after its last byte; a hold covers HOLD cycles from then.
  always @(negedge clk) begin : cmpProc
    evt_t       e;
    logic [12:0] expV;
    logic [12:0] actV;
    if (rst) begin
      mEnd1 = 0; mEnd2 = 0; mUp1 = 1'b0; mUp2 = 1'b0;
      mStartValid = 1'b0; mStartAt = 0; mErr = 0;
    end else begin
      while (evq.size() > 0 && evq[0].at <= cyc) begin
        e = evq.pop_front();
        case (e.kind)
          K_START: begin mStartValid = 1'b1; mStartAt = e.at; end
          K_UP1:   begin mUp1 = 1'b1; mEnd1 = e.at + HOLD; end
          K_DN1:   begin mUp1 = 1'b0; mEnd1 = e.at + HOLD; end
          K_UP2:   begin mUp2 = 1'b1; mEnd2 = e.at + HOLD; end
          K_DN2:   begin mUp2 = 1'b0; mEnd2 = e.at + HOLD; end
          default: if (mErr < 255) mErr++;
        endcase
      end
      expV = {mStartValid && (mStartAt == cyc),
              (cyc < mEnd1) && mUp1, (cyc < mEnd1) && !mUp1,
              (cyc < mEnd2) && mUp2, (cyc < mEnd2) && !mUp2,
              8'(mErr)};
      actV = {o_Game_Start, o_Paddle_Up_P1, o_Paddle_Dn_P1,
              o_Paddle_Up_P2, o_Paddle_Dn_P2, o_Err_Count};
      nChecks++;
      if (actV === expV) nPass++;
      else $display("[TB] FAIL outputs@cycle%0d: got %h, expected %h (start,u1,d1,u2,d2,err)",
                    cyc, actV, expV);
      if (o_Game_Start) begin cntStart++; lastStartCyc = cyc; end
      cntUp1 += int'(o_Paddle_Up_P1);
      cntDn1 += int'(o_Paddle_Dn_P1);
      cntUp2 += int'(o_Paddle_Up_P2);
      cntDn2 += int'(o_Paddle_Dn_P2);
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic sendByte(input logic [7:0] b, output int unsigned at);
    dv = 1'b1; rxByte = b; at = cyc + 1;
    @(posedge clk); #1;
    dv = 1'b0;
  endtask

  function automatic logic [7:0] goodSum(input logic [7:0] cmd, input logic [7:0] arg);
    return 8'hA5 ^ cmd ^ arg;
  endfunction

  function automatic int classify(input logic [7:0] cmd, input logic [7:0] arg, input bit sumOk);
    if (!sumOk) return K_ERR;
    if (cmd == 8'h53) return K_START;
    if (arg != 8'h01 && arg != 8'h02) return K_ERR;
    if (cmd == 8'h55) return (arg == 8'h01) ? K_UP1 : K_UP2;
    if (cmd == 8'h44) return (arg == 8'h01) ? K_DN1 : K_DN2;
    return K_ERR;
  endfunction

  // Sends the first nSend bytes of a packet; a short packet is left to time out.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [7:0] arg, input logic [7:0] sum,
                               input int gapMax, input int nSend, output int unsigned lastAt);
    logic [7:0] pkt [4];
    evt_t       ev;
    bit         sumOk;
    pkt[0] = 8'hA5; pkt[1] = cmd; pkt[2] = arg; pkt[3] = sum;
    sumOk = 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
    sumOk = (sum == goodSum(cmd, arg));
`endif
    lastAt = 0;
    for (int i = 0; i < nSend; i++) begin
      if (i > 0 && gapMax > 0) idle($urandom_range(gapMax));
      sendByte(pkt[i], lastAt);
    end
    if (nSend >= PKT_LEN) begin
      ev.at = lastAt + 2; ev.kind = classify(cmd, arg, sumOk);
      evq.push_back(ev);
      idle(1);
    end else begin
      ev.at = lastAt + TMO + 1; ev.kind = K_ERR;
      evq.push_back(ev);
      idle(TMO + 5);
    end
  endtask

  initial begin : stimProc
    int unsigned s;
    int          b0, b1;
    logic [7:0]  cmd, arg, sum, gb;
    int          r, nSend;

    idle(3);
    rst = 1'b0;
    idle(1);
    checkOutput("reset_err", int'(o_Err_Count), 0);
    checkOutput("reset_start", int'(o_Game_Start), 0);
    checkOutput("reset_paddles", int'({o_Paddle_Up_P1, o_Paddle_Dn_P1, o_Paddle_Up_P2, o_Paddle_Dn_P2}), 0);

    b0 = cntStart;
    applyStimulus(8'h53, 8'h00, 8'hF6, 0, PKT_LEN, s);
    idle(4);
    checkOutput("start_pulse_count", cntStart - b0, 1);
    checkOutput("start_pulse_cycle", int'(lastStartCyc), int'(s + 2));

    b0 = cntUp1;
    applyStimulus(8'h55, 8'h01, goodSum(8'h55, 8'h01), 0, PKT_LEN, s);
    idle(HOLD + 4);
    checkOutput("up1_hold_cycles", cntUp1 - b0, 16);

    b0 = cntUp2; b1 = cntDn2;
    applyStimulus(8'h55, 8'h02, goodSum(8'h55, 8'h02), 0, PKT_LEN, s);
    idle(4);
    applyStimulus(8'h44, 8'h02, goodSum(8'h44, 8'h02), 0, PKT_LEN, s);
    idle(HOLD + 4);
    checkOutput("up2_before_reverse", cntUp2 - b0, 5 + PKT_LEN);
    checkOutput("dn2_hold_cycles", cntDn2 - b1, 16);

    applyStimulus(8'h58, 8'h00, goodSum(8'h58, 8'h00), 0, PKT_LEN, s);
    idle(3);
    checkOutput("err_unknown_cmd", int'(o_Err_Count), 1);
    applyStimulus(8'h55, 8'h03, goodSum(8'h55, 8'h03), 0, PKT_LEN, s);
    idle(3);
    checkOutput("err_bad_arg", int'(o_Err_Count), 2);
`ifdef UART_CMD_CHECKSUM_EN
    applyStimulus(8'h53, 8'h00, 8'h00, 0, PKT_LEN, s);
    idle(3);
    checkOutput("err_bad_sum", int'(o_Err_Count), 3);
    b0 = cntStart;
    applyStimulus(8'h53, 8'h00, 8'hF6, 0, PKT_LEN, s);
    idle(3);
    checkOutput("start_with_sum", cntStart - b0, 1);
`endif

    applyStimulus(8'h53, 8'h00, 8'hF6, 0, 2, s);
    checkOutput("err_timeout", int'(o_Err_Count), ERR_AFTER_TMO);
    b0 = cntStart;
    applyStimulus(8'h53, 8'h00, 8'hF6, 0, PKT_LEN, s);
    idle(3);
    checkOutput("start_after_timeout", cntStart - b0, 1);

    applyStimulus(8'h55, 8'h01, goodSum(8'h55, 8'h01), 0, PKT_LEN, s);
    idle(5);
    rst = 1'b1;
    evq.delete();
    #1;
    checkOutput("async_reset_up1", int'(o_Paddle_Up_P1), 0);
    checkOutput("async_reset_err", int'(o_Err_Count), 0);
    idle(3);
    rst = 1'b0;
    idle(2);
    checkOutput("err_after_reset", int'(o_Err_Count), 0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(4) == 0) begin
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h00;
        sendByte(gb, s);
        idle(1 + $urandom_range(2));
      end
      r = $urandom_range(3);
      cmd = (r == 0) ? 8'h53 : (r == 1) ? 8'h55 : (r == 2) ? 8'h44 : 8'($urandom);
      arg = ($urandom_range(2) != 0) ? 8'(1 + $urandom_range(1)) : 8'($urandom_range(3));
      sum = ($urandom_range(7) == 0) ? 8'($urandom) : goodSum(cmd, arg);
      nSend = ($urandom_range(9) == 0) ? 1 + $urandom_range(PKT_LEN - 2) : PKT_LEN;
      applyStimulus(cmd, arg, sum, ($urandom_range(2) == 0) ? 12 : 2, nSend, s);
      idle($urandom_range(3));
    end
    idle(HOLD + 4);

    for (int n = 0; n < 260; n++) begin
      applyStimulus(8'h58, 8'h00, goodSum(8'h58, 8'h00), 0, PKT_LEN, s);
    end
    idle(4);
    checkOutput("err_saturated", int'(o_Err_Count), 255);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
